// File: rtl/mem_bus_interface.sv
// Memory-side bus stage: latches the datapath's access request, runs a req/ack
// handshake with a wait-state timeout, and stalls the controller via cpu_ready.
module mem_bus_interface #(
  parameter int          TIMEOUT  = 16,
  parameter logic [7:0]  OPEN_BUS = 8'hFF
) (
  input  logic        ph2,
  input  logic        reset,
  input  logic        cpu_mem_en,
  input  logic        cpu_rw,
  input  logic [15:0] cpu_address,
  input  logic [7:0]  cpu_data_out,
  output logic [7:0]  cpu_data_in,
  output logic        cpu_ready,
  output logic        bus_req,
  output logic        bus_we,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_wdata,
  input  logic [7:0]  bus_rdata,
  input  logic        bus_ack,
  output logic        bus_err,
  input  logic        err_clear
);

  // Handshake: bus_req rises after the request edge and stays high, with
  // bus_addr/bus_we/bus_wdata frozen, until the edge that samples bus_ack=1
  // (or the timeout edge); the memory may complete on any ACCESS edge.
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
  localparam logic [CW-1:0] CNT_MAX  = '1;

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          start, ack_done, timeout_hit;

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    start       = 1'b0;
    ack_done    = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_mem_en) begin
          start    = 1'b1;
          cnt_nx   = '0;
          state_nx = ACCESS;
        end
      end
      ACCESS: begin
        // Ack takes priority over a timeout landing on the same edge.
        if (bus_ack) begin
          ack_done = 1'b1;
          state_nx = IDLE;
        end else if (TIMEOUT != 0) begin
          if (cnt == CNT_LAST) begin
            timeout_hit = 1'b1;
            state_nx    = IDLE;
          end else if (cnt != CNT_MAX) begin
            cnt_nx = cnt + CW'(1);
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge ph2 or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      bus_req     <= 1'b0;
      bus_we      <= 1'b0;
      bus_addr    <= 16'h0000;
      bus_wdata   <= 8'h00;
      cpu_data_in <= 8'h00;
      bus_err     <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (start) begin
        bus_addr  <= cpu_address;
        bus_wdata <= cpu_data_out;
        bus_we    <= !cpu_rw;
        bus_req   <= 1'b1;
      end else if (ack_done || timeout_hit) begin
        bus_req <= 1'b0;
      end
      // Only reads update the data register; a dead read returns the open-bus value.
      if (ack_done && !bus_we) begin
        cpu_data_in <= bus_rdata;
      end else if (timeout_hit && !bus_we) begin
        cpu_data_in <= OPEN_BUS;
      end
      if (timeout_hit) begin
        bus_err <= 1'b1;
      end else if (err_clear) begin
        bus_err <= 1'b0;
      end
    end
  end

  assign cpu_ready = (state == IDLE);

endmodule

// File: tb/tb_mem_bus_interface.sv
// Directed bench for mem_bus_interface: driver tasks push expected completions,
// a negedge monitor checks the bus during each access and pops on completion.
module tb_mem_bus_interface;

  localparam int W = 42;  // {addr16, we, wdata8, data8, err, cycles8}

  logic        ph2 = 1'b0;
  logic        reset;
  logic        cpu_mem_en;
  logic        cpu_rw;
  logic [15:0] cpu_address;
  logic [7:0]  cpu_data_out;
  logic [7:0]  cpu_data_in;
  logic        cpu_ready;
  logic        bus_req;
  logic        bus_we;
  logic [15:0] bus_addr;
  logic [7:0]  bus_wdata;
  logic [7:0]  bus_rdata;
  logic        bus_ack;
  logic        bus_err;
  logic        err_clear;

  logic [W-1:0] exp_q[$];
  int           n_total = 0;
  int           n_pass  = 0;
  int           acc_cnt = 0;
  logic         prev_ready = 1'b1;
  logic         mon_en = 1'b0;

  mem_bus_interface #(.TIMEOUT(4), .OPEN_BUS(8'hFF)) dut (
    .ph2          (ph2),
    .reset        (reset),
    .cpu_mem_en   (cpu_mem_en),
    .cpu_rw       (cpu_rw),
    .cpu_address  (cpu_address),
    .cpu_data_out (cpu_data_out),
    .cpu_data_in  (cpu_data_in),
    .cpu_ready    (cpu_ready),
    .bus_req      (bus_req),
    .bus_we       (bus_we),
    .bus_addr     (bus_addr),
    .bus_wdata    (bus_wdata),
    .bus_rdata    (bus_rdata),
    .bus_ack      (bus_ack),
    .bus_err      (bus_err),
    .err_clear    (err_clear)
  );

  // Clock and reset
  always #5 ph2 = ~ph2;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    else n_pass++;
  endtask

  // Monitor / scoreboard
  always @(negedge ph2) begin
    logic [W-1:0] e;
    if (mon_en) begin
      if (!cpu_ready) begin
        acc_cnt++;
        chk("queue_depth_at_access", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q[0];
          chk("bus_req_high", 32'(bus_req), 1);
          chk("bus_addr", 32'(bus_addr), 32'(e[41:26]));
          chk("bus_we", 32'(bus_we), 32'(e[25]));
          chk("bus_wdata", 32'(bus_wdata), 32'(e[24:17]));
        end
      end else begin
        chk("bus_req_idle", 32'(bus_req), 0);
        if (!prev_ready) begin
          chk("queue_depth_at_done", 32'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("cpu_data_in", 32'(cpu_data_in), 32'(e[16:9]));
            chk("bus_err", 32'(bus_err), 32'(e[8]));
            chk("access_cycles", 32'(acc_cnt), 32'(e[7:0]));
          end
          acc_cnt = 0;
        end
      end
    end
    prev_ready = cpu_ready;
  end

  // Driver: one access; ack_cyc/clr_at are 1-based ACCESS edges (0 = never)
  task automatic access(input logic rw, input logic [15:0] addr, input logic [7:0] wd,
                        input int ack_cyc, input logic [7:0] rd, input int clr_at,
                        input logic [7:0] exp_data, input logic exp_err, input int exp_cyc);
    int i;
    bit done;
    @(negedge ph2);
    cpu_mem_en   = 1'b1;
    cpu_rw       = rw;
    cpu_address  = addr;
    cpu_data_out = wd;
    exp_q.push_back({addr, !rw, wd, exp_data, exp_err, 8'(exp_cyc)});
    i = 0;
    done = 1'b0;
    while (!done) begin
      @(negedge ph2);
      if (cpu_ready) begin
        done = 1'b1;
      end else if (i >= 40) begin
        n_total++;
        $display("FAIL access_budget: no completion after %0d cycles, required <= 40", i);
        done = 1'b1;
      end else begin
        i++;
        bus_ack      = (i == ack_cyc);
        bus_rdata    = rd;
        err_clear    = (i == clr_at);
        cpu_mem_en   = 1'($urandom_range(0, 1));
        cpu_address  = 16'($urandom);
        cpu_data_out = 8'($urandom);
      end
    end
    bus_ack    = 1'b0;
    err_clear  = 1'b0;
    cpu_mem_en = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    cpu_mem_en = 1'b0; cpu_rw = 1'b1; cpu_address = 16'h5555; cpu_data_out = 8'h66;
    bus_rdata = 8'h00; bus_ack = 1'b0; err_clear = 1'b0;
    repeat (2) @(negedge ph2);
    chk("rst_bus_req", 32'(bus_req), 0);
    chk("rst_cpu_ready", 32'(cpu_ready), 1);
    chk("rst_bus_addr", 32'(bus_addr), 0);
    chk("rst_bus_wdata", 32'(bus_wdata), 0);
    chk("rst_bus_we", 32'(bus_we), 0);
    chk("rst_cpu_data_in", 32'(cpu_data_in), 0);
    chk("rst_bus_err", 32'(bus_err), 0);
    reset = 1'b0;
    mon_en = 1'b1;

    // Read acked on 2nd ACCESS cycle
    access(1'b1, 16'hFFFC, 8'h11, 2, 8'h34, 0, 8'h34, 1'b0, 2);
    // Zero-wait write leaves read data intact
    access(1'b0, 16'h0200, 8'hA5, 1, 8'hEE, 0, 8'h34, 1'b0, 1);
    // Timed-out read returns open bus and sets bus_err
    access(1'b1, 16'h1234, 8'h22, 0, 8'hEE, 0, 8'hFF, 1'b1, 4);
    // Access still works with bus_err set
    access(1'b1, 16'h0010, 8'h33, 1, 8'h00, 0, 8'h00, 1'b1, 1);
    @(negedge ph2);
    err_clear = 1'b1;
    @(negedge ph2);
    err_clear = 1'b0;
    chk("err_clear", 32'(bus_err), 0);
    // Ack on the timeout edge wins
    access(1'b1, 16'h0300, 8'h44, 4, 8'h5A, 0, 8'h5A, 1'b0, 4);
    // Write timeout with err_clear on the same edge: set wins, data untouched
    access(1'b0, 16'h0400, 8'h3C, 0, 8'hEE, 4, 8'h5A, 1'b1, 4);
    // err_clear during an access, then acked read
    access(1'b1, 16'h0500, 8'h55, 2, 8'hC3, 1, 8'hC3, 1'b0, 2);

    // Spurious ack while idle
    @(negedge ph2);
    bus_ack = 1'b1;
    bus_rdata = 8'h77;
    repeat (3) @(negedge ph2);
    chk("idle_ack_data", 32'(cpu_data_in), 32'h0C3);
    chk("idle_ack_ready", 32'(cpu_ready), 1);
    chk("idle_ack_req", 32'(bus_req), 0);
    bus_ack = 1'b0;

    // Reset in the middle of a read
    @(negedge ph2);
    mon_en = 1'b0;
    cpu_mem_en = 1'b1; cpu_rw = 1'b1; cpu_address = 16'h0600;
    @(negedge ph2);
    cpu_mem_en = 1'b0;
    chk("mid_req_before_reset", 32'(bus_req), 1);
    @(negedge ph2);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_bus_req", 32'(bus_req), 0);
    chk("mid_rst_ready", 32'(cpu_ready), 1);
    chk("mid_rst_data", 32'(cpu_data_in), 0);
    chk("mid_rst_addr", 32'(bus_addr), 0);
    @(negedge ph2);
    reset = 1'b0;
    @(negedge ph2);
    mon_en = 1'b1;
    access(1'b1, 16'h0700, 8'h66, 1, 8'h99, 0, 8'h99, 1'b0, 1);

    repeat (2) @(negedge ph2);
    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
